// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32I load/store funct3 codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - FSM state encoding (lsu_state_t plus ST_* constants)
//   - WORD_ALIGN_MASK, which clears the byte offset of a byte address
// No ports (package).
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE   = 3'd0;
  localparam lsu_state_t ST_LOAD   = 3'd1;
  localparam lsu_state_t ST_RMW_RD = 3'd2;
  localparam lsu_state_t ST_WRITE  = 3'd3;
  localparam lsu_state_t ST_RESP   = 3'd4;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if
// Bundles the request, response and data-memory signals of the load/store
// unit.
//   slave  : the load/store unit's view (takes requests and memory read data,
//            drives responses and memory controls)
//   master : the environment's view (execute stage plus data memory)
// Parameter ADDR_W: byte address width.
//
// Handshake: a request transfers on the rising clk edge where
// req_valid && req_ready. req_ready is high only while the unit is idle.
// There is no response backpressure: resp_valid is a one-cycle pulse that
// the requester must take when it appears.
// -----------------------------------------------------------------------------
interface lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_dout;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_din, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_din, mem_read, mem_write
  );
endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align (combinational)
// Byte-lane helpers for the load/store unit.
//   ld_funct3/ld_lane/ld_word -> ld_data   : lane select + sign/zero extend
//   st_half/st_lane/st_word/st_wdata -> st_merged : byte/half lane merge
//   chk_write/chk_funct3/chk_lane -> chk_err      : misaligned/illegal decode
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data,

  input  logic        st_half,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_word,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_merged,

  input  logic        chk_write,
  input  logic [2:0]  chk_funct3,
  input  logic [1:0]  chk_lane,
  output logic        chk_err
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;

  always_comb begin
    ld_byte   = ld_word[{ld_lane, 3'b000} +: 8];
    ld_half   = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    ld_signed = ~ld_funct3[2];
    case (ld_funct3[1:0])
      2'b00:   ld_data = {{24{ld_byte[7] & ld_signed}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ld_signed}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  always_comb begin
    st_merged = st_word;
    if (st_half) begin
      st_merged[{st_lane[1], 4'b0000} +: 16] = st_wdata[15:0];
    end else begin
      st_merged[{st_lane, 3'b000} +: 8] = st_wdata[7:0];
    end
  end

  // Unsigned variants exist only for loads; W has no unsigned form on RV32.
  always_comb begin
    case (chk_funct3)
      F3_B:    chk_err = 1'b0;
      F3_H:    chk_err = chk_lane[0];
      F3_W:    chk_err = |chk_lane;
      F3_BU:   chk_err = chk_write;
      F3_HU:   chk_err = chk_write | chk_lane[0];
      default: chk_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Request-side front end for a word-addressed data memory. Turns RV32I
// byte/half/word loads and stores into word accesses; sub-word stores are
// done as read-modify-write, loads are sign/zero extended, and misaligned
// or illegal requests complete with resp_err without touching memory.
//
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   bus (slave)    : request/response handshake and memory port (lsu_if)
//   dbg_state      : current FSM state
//   stat_loads/stat_stores/stat_errs : saturating completion counters,
//                    present only when LSU_STATS_EN is defined
//
// Parameters: ADDR_W byte address width, DATA_W data width (32 only).
// Optional feature macro: LSU_STATS_EN.
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  lsu_if.slave       bus,
  output lsu_state_t dbg_state
`ifdef LSU_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  lsu_state_t        state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              err_q, err_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic              accept;
  logic [31:0]       ld_data;
  logic [31:0]       st_merged;
  logic              chk_err;

  lsu_align u_align (
    .ld_funct3  (f3_q),
    .ld_lane    (addr_q[1:0]),
    .ld_word    (bus.mem_dout),
    .ld_data    (ld_data),
    .st_half    (f3_q[0]),
    .st_lane    (addr_q[1:0]),
    .st_word    (word_q),
    .st_wdata   (wdata_q),
    .st_merged  (st_merged),
    .chk_write  (bus.req_write),
    .chk_funct3 (bus.req_funct3),
    .chk_lane   (bus.req_addr[1:0]),
    .chk_err    (chk_err)
  );

  assign accept = bus.req_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    word_d       = word_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d = bus.req_write;
          f3_d    = bus.req_funct3;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = chk_err;
          if (chk_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!bus.req_write) begin
            state_d = ST_LOAD;
          end else if (bus.req_funct3 == F3_W) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_LOAD: begin
        // Extract straight from the memory word so the response is
        // registered on the same edge that captures the word.
        word_d       = bus.mem_dout;
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = ld_data;
      end
      ST_RMW_RD: begin
        word_d  = bus.mem_dout;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      word_q       <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      word_q       <= word_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Memory controls decode straight from state so reset removes them at once.
  assign bus.mem_read   = (state_q == ST_LOAD) || (state_q == ST_RMW_RD);
  assign bus.mem_write  = (state_q == ST_WRITE);
  assign bus.mem_addr   = addr_q & WORD_ALIGN_MASK[ADDR_W-1:0];
  assign bus.mem_din    = (f3_q == F3_W) ? wdata_q : st_merged;

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;

  assign dbg_state      = state_q;

`ifdef LSU_STATS_EN
  logic [31:0] stat_loads_q, stat_loads_d;
  logic [31:0] stat_stores_q, stat_stores_d;
  logic [31:0] stat_errs_q, stat_errs_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    stat_loads_d  = stat_loads_q;
    stat_stores_d = stat_stores_q;
    stat_errs_d   = stat_errs_q;
    if (state_q == ST_RESP) begin
      if (err_q) begin
        stat_errs_d = sat_inc(stat_errs_q);
      end else if (write_q) begin
        stat_stores_d = sat_inc(stat_stores_q);
      end else begin
        stat_loads_d = sat_inc(stat_loads_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_errs_q   <= '0;
    end else begin
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_errs_q   <= stat_errs_d;
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit: directed vector table, reset
// during a read-modify-write, randomized traffic against a reference model,
// and (with LSU_STATS_EN) the completion counters.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
  import lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(32)) bus ();
  lsu_state_t dbg_state;
`ifdef LSU_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef LSU_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  // ---------------- data memory (64 words) ----------------
  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  assign bus.mem_dout = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (bus.mem_write) mem[bus.mem_addr[7:2]] <= bus.mem_din;
  end

  // ---------------- scoreboard / reference ----------------
  logic [31:0] ref_mem [0:63];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model: size, shift and mask arithmetic from the ISA rules.
  function automatic void ref_access(
    input  logic        w,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [31:0] word,
    output logic [31:0] rdata,
    output logic        err,
    output int          lat,
    output logic [31:0] new_word,
    output int          n_rd,
    output int          n_wr
  );
    int nbytes;
    int sh;
    logic [31:0] mask, v;
    err = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (w && f3[2]) ||
          ((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    nbytes = 1 << f3[1:0];
    if (nbytes > 4) nbytes = 4;
    sh   = 8 * int'(addr[1:0]);
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    rdata = 32'd0;
    new_word = word;
    if (err) begin
      lat = 1; n_rd = 0; n_wr = 0;
    end else if (!w) begin
      v = (word >> sh) & mask;
      if (!f3[2] && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
      rdata = v; lat = 2; n_rd = 1; n_wr = 0;
    end else begin
      new_word = (word & ~(mask << sh)) | ((wd & mask) << sh);
      lat  = (nbytes == 4) ? 2 : 3;
      n_rd = (nbytes == 4) ? 0 : 1;
      n_wr = 1;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic mem_poke(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issues one request and checks latency, response, memory-port activity,
  // the one-cycle response pulse and the return to ready.
  task automatic check_txn(
    input string       tag,
    input logic        w,
    input logic [2:0]  f3,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] exp_rd,
    input logic        exp_err,
    input int          exp_lat,
    input int          exp_nrd,
    input int          exp_nwr,
    input logic [31:0] exp_din
  );
    int c;
    int lat;
    int n_rd;
    int n_wr;
    logic addr_ok;
    logic [31:0] rd;
    logic er;
    logic [31:0] din_seen;
    lat = -1; n_rd = 0; n_wr = 0; addr_ok = 1'b1; rd = '0; er = 1'b0; din_seen = '0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wd;
    c = 0;
    while (!bus.req_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    if (!bus.req_ready) check({tag, "/ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    // Inputs are don't-care after acceptance: scramble them.
    bus.req_valid = 1'b0; bus.req_write = ~w; bus.req_funct3 = 3'b111;
    bus.req_addr = $urandom(); bus.req_wdata = $urandom();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.mem_read) n_rd++;
      if (bus.mem_write) begin
        n_wr++;
        din_seen = bus.mem_din;
      end
      if ((bus.mem_read || bus.mem_write) && bus.mem_addr !== (addr & 32'hFFFF_FFFC)) addr_ok = 1'b0;
      if (bus.resp_valid) begin
        lat = i; rd = bus.resp_rdata; er = bus.resp_err;
        break;
      end
    end
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/resp_err"}, {31'd0, er}, {31'd0, exp_err});
    check({tag, "/resp_rdata"}, rd, exp_rd);
    check({tag, "/mem_read_cycles"}, n_rd, exp_nrd);
    check({tag, "/mem_write_cycles"}, n_wr, exp_nwr);
    check({tag, "/mem_addr"}, {31'd0, addr_ok}, 32'd1);
    if (exp_nwr > 0) check({tag, "/mem_din"}, din_seen, exp_din);
    @(negedge clk);
    check({tag, "/pulse_end"}, {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [17];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m_rd, m_new;
    logic m_err;
    int m_lat, m_nrd, m_nwr;
    logic [31:0] saved;
    int idx;

    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0;

    vecs[0]  = '{1'b0, F3_W,   32'h10, 32'h0,         32'h8000_00FF, 1'b0, 2, 32'h8000_00FF};
    vecs[1]  = '{1'b1, F3_W,   32'h10, 32'h80AA_55CC, 32'h0,         1'b0, 2, 32'h80AA_55CC};
    vecs[2]  = '{1'b0, F3_B,   32'h13, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 32'h80AA_55CC};
    vecs[3]  = '{1'b0, F3_BU,  32'h13, 32'h0,         32'h0000_0080, 1'b0, 2, 32'h80AA_55CC};
    vecs[4]  = '{1'b0, F3_H,   32'h12, 32'h0,         32'hFFFF_80AA, 1'b0, 2, 32'h80AA_55CC};
    vecs[5]  = '{1'b0, F3_HU,  32'h10, 32'h0,         32'h0000_55CC, 1'b0, 2, 32'h80AA_55CC};
    vecs[6]  = '{1'b0, F3_B,   32'h10, 32'h0,         32'hFFFF_FFCC, 1'b0, 2, 32'h80AA_55CC};
    vecs[7]  = '{1'b1, F3_H,   32'h22, 32'h1234_BEEF, 32'h0,         1'b0, 3, 32'hBEEF_2222};
    vecs[8]  = '{1'b0, F3_W,   32'h20, 32'h0,         32'hBEEF_2222, 1'b0, 2, 32'hBEEF_2222};
    vecs[9]  = '{1'b1, F3_B,   32'h11, 32'h0000_00AB, 32'h0,         1'b0, 3, 32'h80AA_ABCC};
    vecs[10] = '{1'b0, F3_W,   32'h21, 32'h0,         32'h0,         1'b1, 1, 32'hBEEF_2222};
    vecs[11] = '{1'b1, F3_BU,  32'h10, 32'hFFFF_FFFF, 32'h0,         1'b1, 1, 32'h80AA_ABCC};
    vecs[12] = '{1'b0, 3'b011, 32'h10, 32'h0,         32'h0,         1'b1, 1, 32'h80AA_ABCC};
    vecs[13] = '{1'b1, F3_H,   32'h13, 32'h5555_5555, 32'h0,         1'b1, 1, 32'h80AA_ABCC};
    vecs[14] = '{1'b0, F3_HU,  32'h22, 32'h0,         32'h0000_BEEF, 1'b0, 2, 32'hBEEF_2222};
    vecs[15] = '{1'b0, F3_H,   32'h22, 32'h0,         32'hFFFF_BEEF, 1'b0, 2, 32'hBEEF_2222};
    vecs[16] = '{1'b1, F3_B,   32'h23, 32'h0000_0077, 32'h0,         1'b0, 3, 32'h77EF_2222};

    // Reset state while reset is held.
    #12;
    check("reset/req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("reset/resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("reset/resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("reset/resp_rdata", bus.resp_rdata, 32'd0);
    check("reset/mem_rw", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("reset/state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 64; i++) mem_poke(6'(i), $urandom());
    mem_poke(6'd4, 32'h8000_00FF);
    mem_poke(6'd8, 32'h1111_2222);
    mem_poke(6'd12, 32'h5555_5555);

    // Directed table.
    for (int i = 0; i < 17; i++) begin
      idx = int'(vecs[i].addr[7:2]);
      ref_access(vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata, ref_mem[idx],
                 m_rd, m_err, m_lat, m_new, m_nrd, m_nwr);
      check_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat, m_nrd, m_nwr, vecs[i].exp_mem);
      check($sformatf("vec%0d/mem_word", i), mem[idx], vecs[i].exp_mem);
      ref_mem[idx] = vecs[i].exp_mem;
    end

    // Reset asserted while an SB is in WRITE.
    saved = mem[12];
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = F3_B;
    bus.req_addr = 32'h31; bus.req_wdata = 32'h0000_00A5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_wr/rmw_read", {31'd0, bus.mem_read}, 32'd1);
    @(negedge clk);
    check("rst_wr/write_phase", {31'd0, bus.mem_write}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_wr/mem_write_drop", {31'd0, bus.mem_write}, 32'd0);
    check("rst_wr/mem_read", {31'd0, bus.mem_read}, 32'd0);
    check("rst_wr/req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_wr/state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (bus.resp_valid) seen++;
      end
      check("rst_wr/no_resp", seen, 0);
    end
    check("rst_wr/mem_unchanged", mem[12], saved);
    check_txn("rst_wr/reload", 1'b0, F3_W, 32'h30, 32'h0, saved, 1'b0, 2, 1, 0, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      logic w;
      logic [2:0] f3;
      logic [31:0] addr, wd;
      w    = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 255));
      wd   = $urandom();
      idx  = int'(addr[7:2]);
      ref_access(w, f3, addr, wd, ref_mem[idx], m_rd, m_err, m_lat, m_new, m_nrd, m_nwr);
      check_txn($sformatf("rnd%0d", n), w, f3, addr, wd, m_rd, m_err, m_lat, m_nrd, m_nwr, m_new);
      ref_mem[idx] = m_new;
      check($sformatf("rnd%0d/mem_word", n), mem[idx], ref_mem[idx]);
    end

`ifdef LSU_STATS_EN
    do_reset();
    check("stats/reset_loads", stat_loads, 32'd0);
    check("stats/reset_stores", stat_stores, 32'd0);
    check("stats/reset_errs", stat_errs, 32'd0);
    begin
      logic [2:0] s_f3 [6];
      logic s_w [6];
      logic [31:0] s_addr [6];
      s_w[0] = 1'b0; s_f3[0] = F3_W;  s_addr[0] = 32'h40;
      s_w[1] = 1'b0; s_f3[1] = F3_BU; s_addr[1] = 32'h45;
      s_w[2] = 1'b1; s_f3[2] = F3_W;  s_addr[2] = 32'h48;
      s_w[3] = 1'b0; s_f3[3] = F3_HU; s_addr[3] = 32'h4A;
      s_w[4] = 1'b1; s_f3[4] = F3_H;  s_addr[4] = 32'h4C;
      s_w[5] = 1'b0; s_f3[5] = F3_W;  s_addr[5] = 32'h42;
      for (int i = 0; i < 6; i++) begin
        idx = int'(s_addr[i][7:2]);
        ref_access(s_w[i], s_f3[i], s_addr[i], 32'hCAFE_F00D, ref_mem[idx],
                   m_rd, m_err, m_lat, m_new, m_nrd, m_nwr);
        check_txn($sformatf("stat%0d", i), s_w[i], s_f3[i], s_addr[i], 32'hCAFE_F00D,
                  m_rd, m_err, m_lat, m_nrd, m_nwr, m_new);
        ref_mem[idx] = m_new;
      end
    end
    check("stats/loads", stat_loads, 32'd3);
    check("stats/stores", stat_stores, 32'd2);
    check("stats/errs", stat_errs, 32'd1);
    do_reset();
    check("stats/clr_loads", stat_loads, 32'd0);
    check("stats/clr_stores", stat_stores, 32'd0);
    check("stats/clr_errs", stat_errs, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Request-side front end for the word-addressed data memory. Sits between the execute stage and the data memory.
- Converts RV32I byte, halfword and word loads/stores into word accesses on the memory port.
- Sub-word stores use a read-modify-write sequence; loads are sign- or zero-extended.
- Misaligned or illegal accesses are flagged without touching memory.

Parameters:
- ADDR_W, 32, width of byte address
- DATA_W, 32, data word width (fixed to 32; parameter for documentation only)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data (low byte/half used for B/H)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned/illegal access, valid with resp_valid
- mem_addr  out  ADDR_W  word-aligned address {req_addr[31:2],2'b00}
- mem_din  out  32  write data to memory
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable (memory writes on clk edge)
- mem_dout  in  32  combinational read data from memory

Behaviour:
- Reset (async, any state): state=IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_read=0, mem_write=0. Any pending request or write is dropped.
- Request capture:
  - Accept on the clk edge where req_valid & req_ready.
  - req_write, req_funct3, req_addr and req_wdata are registered then; inputs are don't-care afterwards.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Transitions from IDLE on accept:
  - error → RESP
  - load → LOAD
  - store word → WRITE
  - store B/H → RMW_RD
- Further transitions: LOAD→RESP, RMW_RD→WRITE, WRITE→RESP, RESP→IDLE (unconditional; no backpressure).
- Error conditions:
  - funct3 in {011,110,111}
  - store with funct3[2]=1
  - H/HU with addr[0]≠0
  - W with addr[1:0]≠0
- Memory outputs by state:
  - LOAD and RMW_RD: mem_read=1.
  - WRITE: mem_write=1; mem_din = wdata for W, otherwise the merged word.
  - All other states: mem_read=0, mem_write=0.
  - mem_addr is driven from the registered address in every non-IDLE state.
- Capture and merge:
  - LOAD and RMW_RD capture mem_dout at the end of the state.
  - Merge in WRITE replaces byte lane addr[1:0] (B) or half lane addr[1] (H) of the captured word with the low bits of wdata.
- Load extract:
  - Select lane by addr[1:0]/addr[1].
  - funct3[2]=0 sign-extends; funct3[2]=1 zero-extends to 32 bits.
- Latency (accept edge = T; count in cycles after T):
  - error: resp at T+1
  - load: resp at T+2
  - word store: resp at T+2
  - sub-word store: resp at T+3
  - Next accept is earliest at the edge ending RESP+1 (req_ready high again in IDLE).
- resp_valid, resp_err and resp_rdata are registered, high/valid for exactly one cycle in RESP.
- Memory is never accessed on error.

Optional Feature:
- Macro: LSU_STATS_EN.
- Defined: adds outputs stat_loads, stat_stores, stat_errs (each 32-bit).
  - Incremented at the RESP cycle per completed access type.
  - Errors count only in stat_errs.
  - Saturate at 32'hFFFFFFFF; cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - state encoding typedef (lsu_state_t)
  - word-align mask constant
- Sub-module lsu_align (combinational):
  - load lane-extract/extend
  - store lane-merge
  - error decode
- FSM and registers stay in load_store_unit.

Test Plan:
- LW at addr 0x10, memory word 4 = 0x8000_00FF → resp_valid at T+2, resp_rdata=0x8000_00FF, resp_err=0, mem_read high during LOAD.
- LB addr 0x13, LBU addr 0x13 with word 0x80AA_55CC → LB rdata 0xFFFF_FF80; LBU rdata 0x0000_0080.
- SH addr 0x22, wdata 0x1234_BEEF, existing word 0x1111_2222 at 0x20:
  - RMW_RD then WRITE with mem_din=0xBEEF_2222
  - resp at T+3
  - subsequent LW 0x20 returns 0xBEEF_2222.
- LW addr 0x21, and a store with funct3=100 → resp at T+1 with resp_err=1, rdata=0, mem_read/mem_write never asserted.
- Assert reset during WRITE of an SB → mem_write drops immediately, no memory update, state IDLE, req_ready=1, no resp_valid.
- LSU_STATS_EN: 3 loads, 2 stores, 1 error → stat_loads=3, stat_stores=2, stat_errs=1; reset clears all to 0.
